// File: rtl/ysyx_24090005_seq_ctrl.sv
// Multi-cycle sequencer: owns the PC and the single memory port, stepping each instruction
// through FETCH, EXEC, MEM and WB, and gating register-file writes and PC updates.
module ysyx_24090005_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_ebreak,
  input  logic        rd_wen,
  input  logic [31:0] next_pc,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        rf_wen,
  output logic [31:0] load_data,
  output logic        halt,
  output logic        err,
  output logic [31:0] instret
);

  localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] load_q;
  logic [31:0] instret_q;
  logic        halt_q;
  logic        err_q;
  logic [7:0]  wait_q;
  logic        timed_out;

  // An ack on the cycle the counter hits the limit still wins over the fault.
  assign timed_out = (wait_q == TimeoutCnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0000_0013;
      load_q    <= '0;
      instret_q <= '0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
      wait_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          wait_q  <= '0;
          state_q <= StFetch;
        end
        StFetch: begin
          if (mem_ack) begin
            inst_q  <= mem_rdata;
            wait_q  <= '0;
            state_q <= StExec;
          end else if (timed_out) begin
            err_q   <= 1'b1;
            halt_q  <= 1'b1;
            state_q <= StHalt;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StExec: begin
          if (is_ebreak) begin
            halt_q  <= 1'b1;
            state_q <= StHalt;
          end else if (is_load || is_store) begin
            wait_q  <= '0;
            state_q <= StMem;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (mem_ack) begin
            if (is_load) begin
              load_q <= mem_rdata;
            end
            wait_q  <= '0;
            state_q <= StWb;
          end else if (timed_out) begin
            err_q   <= 1'b1;
            halt_q  <= 1'b1;
            state_q <= StHalt;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StWb: begin
          // A misaligned target faults without retiring; rf_wen has still been issued.
          if (next_pc[1:0] != 2'b00) begin
            err_q   <= 1'b1;
            halt_q  <= 1'b1;
            state_q <= StHalt;
          end else begin
            pc_q      <= next_pc;
            instret_q <= instret_q + 32'd1;
            wait_q    <= '0;
            state_q   <= StFetch;
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StHalt;
        end
      endcase
    end
  end

  // Port and strobe decode depends only on the state, so reset drops mem_req at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_wen    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      StMem: begin
        mem_req   = 1'b1;
        mem_we    = is_store;
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
      end
      StWb: begin
        rf_wen = rd_wen;
      end
      default: begin
        rf_wen = 1'b0;
      end
    endcase
  end

  assign pc_o      = pc_q;
  assign inst_o    = inst_q;
  assign load_data = load_q;
  assign instret   = instret_q;
  assign halt      = halt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ysyx_24090005_seq_ctrl.sv
// Scoreboard bench for ysyx_24090005_seq_ctrl: a driver plays memory and datapath and queues
// expected transactions and retirements; a monitor pops and compares as the DUT presents them.
module tb_ysyx_24090005_seq_ctrl;

  localparam logic [31:0] ResetPc = 32'h8000_0000;
  localparam int unsigned Timeout = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc_o, inst_o, next_pc, ls_addr, ls_wdata, load_data, instret;
  logic        is_load, is_store, is_ebreak, rd_wen, rf_wen, halt, err;

  always #5 clk = ~clk;

  ysyx_24090005_seq_ctrl #(
    .RESET_PC(ResetPc),
    .TIMEOUT (Timeout)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .pc_o     (pc_o),
    .inst_o   (inst_o),
    .is_load  (is_load),
    .is_store (is_store),
    .is_ebreak(is_ebreak),
    .rd_wen   (rd_wen),
    .next_pc  (next_pc),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .rf_wen   (rf_wen),
    .load_data(load_data),
    .halt     (halt),
    .err      (err),
    .instret  (instret)
  );

  typedef enum int {KAlu, KLoad, KStore, KEbreak} kind_e;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_exp_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        rf;
    logic [31:0] ld;
    int          len;
  } ret_exp_t;
  typedef struct {
    kind_e       kind;
    logic [31:0] inst;
    logic        rdw;
    logic [31:0] npc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          df;
    int          dm;
    bit          abort;
  } inst_t;

  mem_exp_t    exp_mem[$];
  ret_exp_t    exp_ret[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rf_cnt = 0;
  logic [31:0] pc_m, instret_m, load_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic bail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Monitor: samples 2 time units after each falling edge.
  initial begin : monitor
    logic [31:0] prev_cnt;
    logic [31:0] prev_ld;
    logic        prev_rf;
    int          last_cyc;
    ret_exp_t    e;
    prev_cnt = '0;
    prev_ld  = '0;
    prev_rf  = 1'b0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_cnt = '0;
        prev_ld  = '0;
        prev_rf  = 1'b0;
        last_cyc = cyc + 2;
        continue;
      end
      if (rf_wen) rf_cnt++;
      if (mem_req) begin
        if (exp_mem.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_req: got request addr %h, expected none", mem_addr);
        end else begin
          check32("mem_addr", mem_addr, exp_mem[0].addr);
          check1("mem_we", mem_we, exp_mem[0].we);
          if (exp_mem[0].we) check32("mem_wdata", mem_wdata, exp_mem[0].wdata);
          if (mem_ack) void'(exp_mem.pop_front());
        end
      end
      if (instret !== prev_cnt) begin
        if (exp_ret.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_retire: got instret %h, expected no retirement", instret);
        end else begin
          e = exp_ret.pop_front();
          check32("retire_instret", instret, e.cnt);
          check32("retire_pc", pc_o, e.pc);
          check1("retire_rf_wen", prev_rf, e.rf);
          check32("retire_load_data", prev_ld, e.ld);
          check32("retire_cycles", cyc - last_cyc, e.len);
        end
        last_cyc = cyc;
      end else if (prev_rf && !err) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_rf_wen: got rf_wen=1 without retirement, expected 0");
      end
      prev_cnt = instret;
      prev_rf  = rf_wen;
      prev_ld  = load_data;
    end
  end

  task automatic wait_req(input string name);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (mem_req !== 1'b1) bail(name);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ack   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_ebreak = 1'b0;
    rd_wen    = 1'b0;
    exp_mem.delete();
    exp_ret.delete();
    repeat (2) @(negedge clk);
    check32("rst_pc", pc_o, ResetPc);
    check32("rst_inst", inst_o, 32'h0000_0013);
    check32("rst_instret", instret, 32'h0);
    check32("rst_load_data", load_data, 32'h0);
    check1("rst_halt", halt, 1'b0);
    check1("rst_err", err, 1'b0);
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_rf_wen", rf_wen, 1'b0);
    rst       = 1'b0;
    pc_m      = ResetPc;
    instret_m = '0;
    load_m    = '0;
    #1;
    check1("idle_mem_req", mem_req, 1'b0);
    @(negedge clk);
    #1;
    check1("first_fetch_req", mem_req, 1'b1);
    check32("first_fetch_addr", mem_addr, ResetPc);
  endtask

  function automatic inst_t mk(input kind_e k, input logic rdw, input logic [31:0] npc,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int df, input int dm);
    inst_t t;
    t.kind  = k;
    t.inst  = (k == KEbreak) ? 32'h0010_0073 : $urandom;
    t.rdw   = rdw;
    t.npc   = npc;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = rdata;
    t.df    = df;
    t.dm    = dm;
    t.abort = 1'b0;
    return t;
  endfunction

  function automatic inst_t rand_inst(input logic [31:0] pc);
    int          k   = $urandom_range(0, 2);
    logic [31:0] npc = ($urandom_range(0, 3) == 0) ? (ResetPc | ($urandom & 32'h0000_0FFC))
                                                    : pc + 32'd4;
    logic        rdw = (k == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    return mk(kind_e'(k), rdw, npc, 32'h8000_1000 | ($urandom & 32'h0000_0FFC), $urandom,
              $urandom, $urandom_range(0, Timeout), $urandom_range(0, Timeout));
  endfunction

  // Queues the expected behaviour of one instruction, then plays memory/datapath for it.
  task automatic run_inst(input inst_t t);
    bit ldst = (t.kind == KLoad) || (t.kind == KStore);
    exp_mem.push_back('{pc_m, 1'b0, 32'h0});
    if (ldst) exp_mem.push_back('{t.addr, t.kind == KStore, t.wdata});
    if (t.kind != KEbreak && t.npc[1:0] == 2'b00 && !t.abort) begin
      if (t.kind == KLoad) load_m = t.rdata;
      instret_m = instret_m + 32'd1;
      exp_ret.push_back('{t.npc, instret_m, t.rdw, load_m, 3 + t.df + (ldst ? 1 + t.dm : 0)});
      pc_m = t.npc;
    end
    wait_req("fetch_req_wait");
    repeat (t.df) @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = t.inst;
    is_load   = (t.kind == KLoad);
    is_store  = (t.kind == KStore);
    is_ebreak = (t.kind == KEbreak);
    rd_wen    = t.rdw;
    next_pc   = t.npc;
    ls_addr   = t.addr;
    ls_wdata  = t.wdata;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    check32("inst_latch", inst_o, t.inst);
    if (ldst) begin
      wait_req("mem_req_wait");
      repeat (t.dm) @(negedge clk);
      if (t.abort) begin
        #3;
        rst = 1'b1;
        #1;
        check1("abort_mem_req", mem_req, 1'b0);
        check32("abort_pc", pc_o, ResetPc);
        check32("abort_instret", instret, 32'h0);
        exp_mem.delete();
        exp_ret.delete();
        return;
      end
      mem_ack   = 1'b1;
      mem_rdata = t.rdata;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  initial begin : watchdog
    #200000;
    bail("watchdog");
  end

  initial begin : driver
    inst_t t;
    int    n;
    int    rf_before;
    mem_rdata = '0;
    next_pc   = '0;
    ls_addr   = '0;
    ls_wdata  = '0;

    // Directed ALU, waited load, store; then random traffic ending in ebreak.
    do_reset();
    run_inst(mk(KAlu, 1'b1, ResetPc + 32'd4, 32'h0, 32'h0, 32'h0, 0, 0));
    run_inst(mk(KLoad, 1'b1, pc_m + 32'd4, 32'h8000_0100, 32'h0, 32'hDEAD_BEEF, 3, 3));
    run_inst(mk(KStore, 1'b0, pc_m + 32'd4, 32'h8000_0104, 32'h1234_5678, 32'h0, 0, 0));
    for (int i = 0; i < 40; i++) run_inst(rand_inst(pc_m));
    run_inst(mk(KEbreak, 1'b0, pc_m + 32'd4, 32'h0, 32'h0, 32'h0, $urandom_range(0, 2), 0));
    @(negedge clk);
    check1("ebreak_halt", halt, 1'b1);
    check1("ebreak_err", err, 1'b0);
    for (int i = 0; i < 20; i++) begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(negedge clk);
      check1("halt_mem_req", mem_req, 1'b0);
      check32("halt_instret", instret, instret_m);
    end
    check32("halt_load_data", load_data, load_m);
    check32("halt_pc", pc_o, pc_m);
    check32("exp_mem_drained", exp_mem.size(), 32'd0);
    check32("exp_ret_drained", exp_ret.size(), 32'd0);

    // Fetch never acknowledged: faults after TIMEOUT+1 request cycles.
    do_reset();
    exp_mem.push_back('{ResetPc, 1'b0, 32'h0});
    n = 0;
    for (int i = 0; i < 20 && halt !== 1'b1; i++) begin
      if (mem_req) n++;
      @(negedge clk);
      #1;
    end
    check32("timeout_fetch_cycles", n, Timeout + 1);
    check1("timeout_halt", halt, 1'b1);
    check1("timeout_err", err, 1'b1);
    check1("timeout_mem_req", mem_req, 1'b0);

    // Misaligned next PC: faults without retiring, write strobe still issued.
    do_reset();
    rf_before = rf_cnt;
    run_inst(mk(KAlu, 1'b1, ResetPc + 32'd2, 32'h0, 32'h0, 32'h0, 1, 0));
    repeat (3) @(negedge clk);
    #3;
    check1("misalign_err", err, 1'b1);
    check1("misalign_halt", halt, 1'b1);
    check32("misalign_pc", pc_o, ResetPc);
    check32("misalign_instret", instret, 32'h0);
    check32("misalign_rf_pulses", rf_cnt - rf_before, 32'd1);

    // Asynchronous reset in the middle of a data access, then recovery.
    do_reset();
    run_inst(mk(KAlu, 1'b0, ResetPc + 32'd4, 32'h0, 32'h0, 32'h0, 0, 0));
    run_inst(mk(KAlu, 1'b1, pc_m + 32'd4, 32'h0, 32'h0, 32'h0, 0, 0));
    t = mk(KLoad, 1'b1, pc_m + 32'd4, 32'h8000_0200, 32'h0, 32'hCAFE_F00D, 0, 2);
    t.abort = 1'b1;
    run_inst(t);
    do_reset();
    run_inst(mk(KLoad, 1'b1, ResetPc + 32'd4, 32'h8000_0300, 32'h0, 32'h0BAD_CAFE, 1, 1));
    run_inst(mk(KAlu, 1'b1, pc_m + 32'd4, 32'h0, 32'h0, 32'h0, 2, 0));
    run_inst(mk(KEbreak, 1'b0, pc_m + 32'd4, 32'h0, 32'h0, 32'h0, 0, 0));
    repeat (3) @(negedge clk);
    check32("final_instret", instret, 32'd2);
    check32("final_exp_ret", exp_ret.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
